// File: rtl/variable_rshift_pipeline_if.sv
// Operand/result bundle for the three-stage variable right shifter.
// The optional sticky signal exists only when SHIFT_STICKY_EN is defined.
interface variable_rshift_pipeline_if;
   logic       en;           // pipeline advance enable
   logic       in_valid;     // operand fields carry an operation
   logic [7:0] a;            // operand
   logic [2:0] shift_width;  // right-shift amount 0..7
   logic       arith;        // 1 = sign fill, 0 = zero fill
   logic [7:0] shifted_a;    // registered result
   logic       out_valid;    // shifted_a holds a valid result
`ifdef SHIFT_STICKY_EN
   logic       sticky;       // OR of every bit shifted out
`endif

   // Producer side: drives operations, observes results.
   modport master (
      output en, in_valid, a, shift_width, arith,
      input  shifted_a, out_valid
`ifdef SHIFT_STICKY_EN
      , input sticky
`endif
   );

   // Shifter side: consumes operations, drives results.
   modport slave (
      input  en, in_valid, a, shift_width, arith,
      output shifted_a, out_valid
`ifdef SHIFT_STICKY_EN
      , output sticky
`endif
   );
endinterface

// File: rtl/variable_rshift_pipeline.sv
// Three-stage pipelined 8-bit right shifter (logical or arithmetic).
// Stage 1 shifts by 1, stage 2 by 2, stage 3 by 4, each selected by one bit
// of the operation's own shift_width, which travels down the pipe with it.
// Optional feature: define SHIFT_STICKY_EN to add the sticky output, the OR
// of every bit discarded by the operation, aligned with shifted_a.
module variable_rshift_pipeline (
   input logic                          clk_i,
   input logic                          rst_i,
   variable_rshift_pipeline_if.slave    bus
);

   // Everything an operation carries from stage to stage.
   typedef struct packed {
      logic       valid;
      logic       arith;
      logic [2:0] shift_width;
      logic [7:0] data;
`ifdef SHIFT_STICKY_EN
      logic       sticky;
`endif
   } stage_t;

   stage_t s1_d, s1_q;
   stage_t s2_d, s2_q;
   stage_t s3_d, s3_q;

   // Fill bit for each stage. An arithmetic shift never changes bit 7, so the
   // current data's msb is always the operand's original sign bit.
   logic fill_1, fill_2, fill_3;

   assign fill_1 = bus.arith & bus.a[7];
   assign fill_2 = s1_q.arith & s1_q.data[7];
   assign fill_3 = s2_q.arith & s2_q.data[7];

   // Stage 1: conditional shift by 1 on the incoming operand.
   always_comb begin
      s1_d             = '0;
      s1_d.valid       = bus.in_valid;
      s1_d.arith       = bus.arith;
      s1_d.shift_width = bus.shift_width;
      s1_d.data        = bus.shift_width[0] ? {fill_1, bus.a[7:1]} : bus.a;
`ifdef SHIFT_STICKY_EN
      s1_d.sticky      = bus.shift_width[0] & bus.a[0];
`endif
   end

   // Stage 2: conditional shift by 2 using the operation's own bit 1.
   always_comb begin
      s2_d      = s1_q;
      s2_d.data = s1_q.shift_width[1] ? {{2{fill_2}}, s1_q.data[7:2]} : s1_q.data;
`ifdef SHIFT_STICKY_EN
      s2_d.sticky = s1_q.sticky | (s1_q.shift_width[1] & (|s1_q.data[1:0]));
`endif
   end

   // Stage 3: conditional shift by 4 using the operation's own bit 2.
   always_comb begin
      s3_d      = s2_q;
      s3_d.data = s2_q.shift_width[2] ? {{4{fill_3}}, s2_q.data[7:4]} : s2_q.data;
`ifdef SHIFT_STICKY_EN
      s3_d.sticky = s2_q.sticky | (s2_q.shift_width[2] & (|s2_q.data[3:0]));
`endif
   end

   // Pipeline registers: reset dominates, otherwise advance only while en is high.
   // NOTE: every stage (data included) is reset, so a flushed pipe shows 8'h00
   // rather than stale results; non-blocking assignments keep the three stages
   // shifting as one coherent register chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else if (bus.en) begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign bus.shifted_a = s3_q.data;
   assign bus.out_valid = s3_q.valid;
`ifdef SHIFT_STICKY_EN
   assign bus.sticky    = s3_q.sticky;
`endif

endmodule

// File: doc/variable_rshift_pipeline.md
VARIABLE_RSHIFT_PIPELINE -- requirements
Module: variable_rshift_pipeline

Interface
REQ-001 Parameters: none; data width fixed at 8 bits, shift amount fixed at 3 bits.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  pipeline advance enable; 0 = every stage holds its contents.
REQ-005 in_valid  input  1  a, shift_width and arith carry a valid operation this cycle.
REQ-006 a  input  8  operand.
REQ-007 shift_width  input  3  right-shift amount, 0..7.
REQ-008 arith  input  1  1 = arithmetic shift (sign fill), 0 = logical shift (zero fill).
REQ-009 shifted_a  output  8  registered result, a >> shift_width.
REQ-010 out_valid  output  1  shifted_a holds a valid result.
REQ-011 sticky  output  1  OR of all bits shifted out (only when SHIFT_STICKY_EN is defined).

Function
REQ-012 Three register stages: stage 1 shifts by 1 if shift_width[0], stage 2 by 2 if bit [1], stage 3 by 4 if bit [2]; otherwise each stage passes its data unchanged.
REQ-013 Unused shift bits and the arith flag are pipelined with the data, so each operation uses only its own controls.
REQ-014 Fill bits: 0 when the operation's arith = 0; operand bit 7 when arith = 1, applied at every stage.
REQ-015 Latency: an operation accepted on edge N (en = 1) appears on shifted_a / out_valid after edge N+2, given en = 1 on all three edges.
REQ-016 Throughput: one operation per en-high cycle; back-to-back operations allowed with no bubble.
REQ-017 in_valid is pipelined alongside the data; out_valid = stage-3 valid bit.
REQ-018 Stages with valid = 0 still shift data, but the result is don't-care; out_valid = 0 marks it invalid.
REQ-019 en = 0: all data, control and valid registers hold; inputs that cycle are ignored, including in_valid.
REQ-020 shift_width = 0: result equals a exactly, in both modes.
REQ-021 shift_width = 7: logical gives {7'b0, a[7]}; arithmetic gives 8'hFF if a[7] = 1, else 8'h00.
REQ-022 Simultaneous RST and en: RST wins.

Reset
REQ-023 RST = 1 on a rising edge clears every stage's data, control, valid and sticky bits to 0, regardless of en.
REQ-024 After reset: shifted_a = 8'h00, out_valid = 0, sticky = 0.
REQ-025 Operations in flight when RST asserts are discarded; none reappear after release.
REQ-026 The first edge with RST = 0 accepts a new operation normally.

Configuration
REQ-027 Macro SHIFT_STICKY_EN defined: the sticky port exists.
REQ-028 Each stage ORs the bits it discards into a pipelined sticky bit, aligned with shifted_a.
REQ-029 Sticky obeys the same en hold and reset rules as the data.
REQ-030 Macro not defined: no sticky port and no sticky logic; all other behaviour is unchanged.

Verification
REQ-031 Mode check: a = 8'hB4, shift_width = 3, arith = 0, in_valid = 1, en = 1 -> 3 edges later shifted_a = 8'h16, out_valid = 1, sticky = 1. Same inputs with arith = 1 -> shifted_a = 8'hF6.
REQ-032 Boundaries: a = 8'h80, shift_width = 7 -> arith = 1 gives 8'hFF, arith = 0 gives 8'h01, sticky = 0 in both. a = 8'h5A, shift_width = 0 -> 8'h5A.
REQ-033 Streaming: 8 consecutive operations, a = 8'hFF, shift_width = 0..7, arith = 0 -> outputs 8'hFF, 7F, 3F, 1F, 0F, 07, 03, 01 on consecutive cycles, out_valid held at 1.
REQ-034 Stall: en = 0 for 4 cycles with 2 operations in flight and inputs toggling -> outputs frozen during the stall; after en returns to 1, results emerge in order and are correct.
REQ-035 Reset mid-stream: RST pulsed while 3 operations are in flight -> next edge gives shifted_a = 8'h00, out_valid = 0. With no new in_valid, out_valid stays 0.
REQ-036 Build both with and without SHIFT_STICKY_EN -> data results identical in both builds.
